// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - round-robin writeback arbiter for one register-file write port (optional WB_CONFLICT_CNT_EN)
module rf_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall,
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic [ADDR_W-1:0]        a_rd,
  input  logic [DATA_W-1:0]        a_data,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [ADDR_W-1:0]        b_rd,
  input  logic [DATA_W-1:0]        b_data,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_wR,
  output logic [DATA_W-1:0]        rf_wD,
  output logic [(1<<ADDR_W)-1:0]   pend
`ifdef WB_CONFLICT_CNT_EN
  ,
  output logic [15:0]              conflict_cnt
`endif
);

  typedef enum logic {PRIO_A = 1'b0, PRIO_B = 1'b1} state_e;

  state_e                    state_q, state_d;
  logic                      grant_a, grant_b, granted, both_valid;
  logic [ADDR_W-1:0]         sel_rd;
  logic [DATA_W-1:0]         sel_data;
  logic                      rf_we_q, rf_we_d;
  logic [ADDR_W-1:0]         rf_wr_q, rf_wr_d;
  logic [DATA_W-1:0]         rf_wd_q, rf_wd_d;
  logic [(1<<ADDR_W)-1:0]    pend_q, pend_d;

  assign both_valid = a_valid & b_valid;

  // Grant selection and round-robin priority update; nothing is granted in reset or stall
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    state_d = state_q;
    if (rst_n && !stall) begin
      if (both_valid) begin
        if (state_q == PRIO_A) begin
          grant_a = 1'b1;
          state_d = PRIO_B;
        end else begin
          grant_b = 1'b1;
          state_d = PRIO_A;
        end
      end else if (a_valid) begin
        grant_a = 1'b1;
      end else if (b_valid) begin
        grant_b = 1'b1;
      end
    end
  end

  assign granted = grant_a | grant_b;
  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // Capture the granted write; register 0 is accepted but never written or marked pending
  always_comb begin
    sel_rd   = grant_a ? a_rd   : b_rd;
    sel_data = grant_a ? a_data : b_data;
    rf_we_d  = granted && (sel_rd != '0);
    rf_wr_d  = rf_wr_q;
    rf_wd_d  = rf_wd_q;
    pend_d   = '0;
    if (granted) begin
      rf_wr_d = sel_rd;
      rf_wd_d = sel_data;
    end
    if (rf_we_d) begin
      pend_d[sel_rd] = 1'b1;
    end
  end

  // State and write-port registers, cleared immediately by reset so a pending write is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PRIO_A;
      rf_we_q <= 1'b0;
      rf_wr_q <= '0;
      rf_wd_q <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      rf_we_q <= rf_we_d;
      rf_wr_q <= rf_wr_d;
      rf_wd_q <= rf_wd_d;
      pend_q  <= pend_d;
    end
  end

  assign rf_we = rf_we_q;
  assign rf_wR = rf_wr_q;
  assign rf_wD = rf_wd_q;
  assign pend  = pend_q;

`ifdef WB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  // Saturating count of cycles where both requesters competed for the port
  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (both_valid && !stall && (conflict_cnt_q != 16'hFFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end
  end

  // Conflict counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt_q <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - randomized self-checking bench for rf_wb_arbiter against a behavioural model
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic        a_ready, b_ready;
  logic [4:0]  a_rd = '0, b_rd = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic        rf_we;
  logic [4:0]  rf_wR;
  logic [31:0] rf_wD;
  logic [31:0] pend;
`ifdef WB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt;
`endif

  rf_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .rf_we(rf_we), .rf_wR(rf_wR), .rf_wD(rf_wD), .pend(pend)
`ifdef WB_CONFLICT_CNT_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Register file fed by the DUT, written on the falling edge
  logic [31:0] tb_rf [32];
  always @(negedge clk) if (rf_we) tb_rf[rf_wR] <= rf_wD;

  int checks = 0;
  int fails  = 0;

  // Behavioural model state
  bit          m_turn_a;
  logic        m_we;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;
  logic [31:0] m_pend;
  logic [31:0] m_rf [32];
  int          m_cc;

  logic [1:0]  exp_rdy, obs_rdy;
  logic [37:0] obs_out;
  logic [31:0] obs_pend;

  function automatic logic [37:0] exp_out();
    return {m_we, m_wr, m_wd};
  endfunction

  task automatic model_reset();
    m_turn_a = 1'b1;
    m_we = 1'b0; m_wr = '0; m_wd = '0; m_pend = '0; m_cc = 0;
  endtask

  // Drive one cycle, capture ready and the registered outputs, advance the model
  task automatic step(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                      input logic bv, input logic [4:0] br, input logic [31:0] bd,
                      input logic st);
    bit ga, gb;
    a_valid = av; a_rd = ar; a_data = ad;
    b_valid = bv; b_rd = br; b_data = bd;
    stall = st;
    #1;
    ga = 0; gb = 0;
    if (!st) begin
      if (av && bv) begin
        if (m_turn_a) ga = 1; else gb = 1;
        m_turn_a = !m_turn_a;
        if (m_cc < 65535) m_cc++;
      end else if (av) ga = 1;
      else if (bv) gb = 1;
    end
    exp_rdy = {ga, gb};
    obs_rdy = {a_ready, b_ready};
    @(posedge clk); #1;
    m_we = 1'b0;
    if (ga) begin m_wr = ar; m_wd = ad; m_we = (ar != 0); end
    if (gb) begin m_wr = br; m_wd = bd; m_we = (br != 0); end
    m_pend = m_we ? (32'd1 << m_wr) : 32'd0;
    if (m_we) m_rf[m_wr] = m_wd;
    obs_out  = {rf_we, rf_wR, rf_wD};
    obs_pend = pend;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    a_valid = 1; b_valid = 1; #1;
    checks++;
    if ({a_ready, b_ready, rf_we, rf_wR, rf_wD, pend} !== '0) begin
      fails++;
      $display("FAIL reset_state: rdy=%b we=%b wR=%0d wD=%h pend=%h, required all zero",
               {a_ready, b_ready}, rf_we, rf_wR, rf_wD, pend);
    end
    a_valid = 0; b_valid = 0;
    @(negedge clk); rst_n = 1;
    model_reset();
  endtask

  task automatic test_single();
    step(1, 19, 32'hDEAD_BEEF, 0, 0, 0, 0);
    checks++;
    if (obs_rdy !== 2'b10) begin fails++; $display("FAIL single_ready: got %b required 10", obs_rdy); end
    checks++;
    if (obs_out !== {1'b1, 5'd19, 32'hDEAD_BEEF} || obs_pend !== (32'd1 << 19)) begin
      fails++;
      $display("FAIL single_present: got %h pend %h required %h pend %h", obs_out,
               obs_pend, {1'b1, 5'd19, 32'hDEAD_BEEF}, 32'd1 << 19);
    end
    idle();
    checks++;
    if (obs_out[37] !== 1'b0 || obs_pend !== 32'd0) begin
      fails++; $display("FAIL single_clear: we=%b pend=%h required 0 0", obs_out[37], obs_pend);
    end
  endtask

  task automatic test_alternate();
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 1, 1, 2, 2, 0);
      checks++;
      if (obs_rdy !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        fails++; $display("FAIL alt_grant[%0d]: got %b required %b", i, obs_rdy, (i % 2 == 0) ? 2'b10 : 2'b01);
      end
      checks++;
      if (obs_out !== exp_out() || obs_out[36:32] !== ((i % 2 == 0) ? 5'd1 : 5'd2) || obs_out[37] !== 1'b1) begin
        fails++; $display("FAIL alt_out[%0d]: got %h required %h", i, obs_out, exp_out());
      end
    end
`ifdef WB_CONFLICT_CNT_EN
    checks++;
    if (conflict_cnt !== 16'd4) begin fails++; $display("FAIL alt_conflict_cnt: got %0d required 4", conflict_cnt); end
`endif
    idle();
  endtask

  task automatic test_same_rd();
    for (int i = 0; i < 2; i++) begin
      step(1, 5, 32'h1, 1, 5, 32'h2, 0);
      checks++;
      if (obs_out !== {1'b1, 5'd5, (i == 0) ? 32'h1 : 32'h2}) begin
        fails++; $display("FAIL same_rd_out[%0d]: got %h required %h", i, obs_out, {1'b1, 5'd5, (i == 0) ? 32'h1 : 32'h2});
      end
    end
    idle();
    @(negedge clk); #1;
    checks++;
    if (tb_rf[5] !== 32'h2) begin fails++; $display("FAIL same_rd_reg5: got %h required 00000002", tb_rf[5]); end
  endtask

  task automatic test_rd0();
    step(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0);
    checks++;
    if (obs_rdy !== 2'b10 || obs_out[37] !== 1'b0 || obs_pend !== 32'd0) begin
      fails++; $display("FAIL rd0: rdy=%b we=%b pend=%h required 10 0 0", obs_rdy, obs_out[37], obs_pend);
    end
    idle();
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      step(1, 3, 32'h33, 1, 4, 32'h44, 1);
      checks++;
      if (obs_rdy !== 2'b00 || obs_out[37] !== 1'b0) begin
        fails++; $display("FAIL stall[%0d]: rdy=%b we=%b required 00 0", i, obs_rdy, obs_out[37]);
      end
    end
    step(1, 3, 32'h33, 1, 4, 32'h44, 0);
    checks++;
    if (obs_rdy !== 2'b10 || obs_out !== exp_out()) begin
      fails++; $display("FAIL stall_release: rdy=%b out=%h required 10 %h", obs_rdy, obs_out, exp_out());
    end
    idle();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      step(1, 5'(8 + i), 32'hA000 + i, 0, 0, 0, 0);
      checks++;
      if (obs_out !== exp_out() || obs_out[37] !== 1'b1 || obs_pend !== m_pend) begin
        fails++; $display("FAIL b2b[%0d]: got %h pend %h required %h pend %h", i, obs_out, obs_pend, exp_out(), m_pend);
      end
    end
    idle();
  endtask

  task automatic test_async_reset();
    logic [31:0] saved;
    idle();
    step(1, 1, 32'h1, 1, 2, 32'h2, 0);
    saved = m_rf[9];
    step(0, 0, 0, 1, 9, 32'hBAD0_0009, 0);
    m_rf[9] = saved;
    checks++;
    if (obs_out[37] !== 1'b1) begin fails++; $display("FAIL async_pre: we=%b required 1", obs_out[37]); end
    #2 rst_n = 0;
    a_valid = 1; b_valid = 1;
    #1;
    checks++;
    if ({a_ready, b_ready, rf_we, rf_wR, rf_wD, pend} !== '0) begin
      fails++;
      $display("FAIL async_reset: rdy=%b we=%b wR=%0d wD=%h pend=%h required all zero",
               {a_ready, b_ready}, rf_we, rf_wR, rf_wD, pend);
    end
    #1 rst_n = 1;
    model_reset();
    step(1, 6, 32'h66, 1, 7, 32'h77, 0);
    checks++;
    if (obs_rdy !== 2'b10 || obs_out !== exp_out()) begin
      fails++; $display("FAIL async_first_grant: rdy=%b out=%h required 10 %h", obs_rdy, obs_out, exp_out());
    end
    idle();
    @(negedge clk); #1;
    checks++;
    if (tb_rf[9] !== m_rf[9]) begin fails++; $display("FAIL async_discard: reg9=%h required %h", tb_rf[9], m_rf[9]); end
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 7) == 0);
      checks++;
      if (obs_rdy !== exp_rdy || obs_out !== exp_out() || obs_pend !== m_pend) begin
        fails++;
        if (errs++ < 10)
          $display("FAIL rand[%0d]: rdy=%b out=%h pend=%h required %b %h %h", i, obs_rdy, obs_out, obs_pend,
                   exp_rdy, exp_out(), m_pend);
      end
`ifdef WB_CONFLICT_CNT_EN
      checks++;
      if (conflict_cnt !== 16'(m_cc)) begin fails++; $display("FAIL rand_cc[%0d]: got %0d required %0d", i, conflict_cnt, m_cc); end
`endif
    end
    idle();
    @(negedge clk); #1;
    for (int r = 0; r < 32; r++) begin
      checks++;
      if (tb_rf[r] !== m_rf[r]) begin fails++; $display("FAIL rand_rf[%0d]: got %h required %h", r, tb_rf[r], m_rf[r]); end
    end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin tb_rf[r] = '0; m_rf[r] = '0; end
    model_reset();
    #2;
    test_reset();
    test_single();
    test_alternate();
    test_same_rd();
    test_rd0();
    test_stall();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
